// File: rtl/rx_os_counter_bank_pkg.sv
// ============================================================================
// rx_os_counter_bank_pkg
// Shared PHY definitions used by the LTSSM, the ordered-set decoder and the
// RX ordered-set counter bank.
//   PHY_MAXLANES : widest link the PHY supports
//   os_type_e    : encoding of decoded ordered-set types on the osType buses
// ============================================================================
package rx_os_counter_bank_pkg;

    localparam int PHY_MAXLANES = 16;

    typedef enum logic [2:0] {
        OS_NONE  = 3'd0,
        OS_TS1   = 3'd1,
        OS_TS2   = 3'd2,
        OS_EIOS  = 3'd3,
        OS_EIEOS = 3'd4,
        OS_SKP   = 3'd5,
        OS_IDLE  = 3'd6
    } os_type_e;

endpackage

// File: rtl/rx_os_counter_bank_os_lane_counter.sv
// ============================================================================
// os_lane_counter
// Counts consecutive matching ordered sets on one lane and registers whether
// the run length has reached the target.
//   clk, reset       : clock, asynchronous active-low reset
//   i_enable         : lane enabled and active; 0 holds the lane in clear
//   i_clear          : expected type changed this cycle; clear, ignore osValid
//   i_osValid        : one decoded ordered set present this cycle
//   i_osType         : type of that ordered set
//   i_osMatch        : link/lane/rate fields equal those of the previous OS
//   i_expectedType   : ordered-set type being counted
//   i_target         : run length at which o_reached asserts
//   o_reached        : registered "count >= target" flag
// ============================================================================
module os_lane_counter
    import rx_os_counter_bank_pkg::*;
#(
    parameter int CNTW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_enable,
    input  logic            i_clear,
    input  logic            i_osValid,
    input  logic [2:0]      i_osType,
    input  logic            i_osMatch,
    input  logic [2:0]      i_expectedType,
    input  logic [4:0]      i_target,
    output logic            o_reached
);

    // The compare is done at the wider of the two widths so that a target
    // larger than the counter's saturation value can never be satisfied.
    localparam int CMPW = (CNTW > 5) ? CNTW : 5;

    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cntNext;
    logic [CMPW-1:0] w_cntExt;
    logic [CMPW-1:0] w_tgtExt;
    logic            r_reached;
    logic            w_typeIsExpected;
    logic            w_skipIgnored;

    assign w_typeIsExpected = (i_osType == i_expectedType);
    // SKP may be interleaved inside a TS run; it is transparent unless SKP
    // itself is what we are counting.
    assign w_skipIgnored    = (i_osType == OS_SKP) && (i_expectedType != OS_SKP);

    // Next-count selection. A broken run restarts at 1 when the breaking OS is
    // itself of the expected type (only its fields differed), else at 0.
    always_comb begin
        w_cntNext = r_cnt;
        if (!i_enable || i_clear) begin
            w_cntNext = '0;
        end else if (i_osValid && !w_skipIgnored) begin
            if (w_typeIsExpected && i_osMatch) begin
                w_cntNext = (r_cnt == '1) ? r_cnt : r_cnt + CNTW'(1);
            end else if (w_typeIsExpected) begin
                w_cntNext = CNTW'(1);
            end else begin
                w_cntNext = '0;
            end
        end
    end

    assign w_cntExt = CMPW'(w_cntNext);
    assign w_tgtExt = CMPW'(i_target);

    // The flag is registered from the next count so a hit shows one cycle
    // after its osValid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_reached <= 1'b0;
        end else begin
            r_cnt     <= w_cntNext;
            r_reached <= i_enable && (w_cntExt >= w_tgtExt);
        end
    end

    assign o_reached = r_reached;

endmodule

// File: rtl/rx_os_counter_bank.sv
// ============================================================================
// rx_os_counter_bank
// Bank of per-lane ordered-set run counters used by the LTSSM to decide when
// enough consecutive TS1/TS2/etc. have been seen on every active lane.
//   clk, reset             : clock, asynchronous active-low reset
//   resetOsCheckers[15:0]  : per-lane enable; 0 holds the lane cleared
//   numberOfDetectedLanes  : lanes in use; lane i active iff i < value
//   expectedType[2:0]      : ordered-set type being counted
//   comparatorsCount[4:0]  : per-lane target run length
//   osValid[MAXLANES-1:0]  : per-lane decoded-OS strobe
//   osType[3*MAXLANES-1:0] : per-lane OS type, lane i at [3i+2:3i]
//   osMatch[MAXLANES-1:0]  : per-lane "fields equal previous OS"
//   countersComparators    : per-lane registered "target reached"
// ============================================================================
module rx_os_counter_bank
    import rx_os_counter_bank_pkg::*;
#(
    parameter int MAXLANES = PHY_MAXLANES,
    parameter int CNTW     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           resetOsCheckers,
    input  logic [4:0]            numberOfDetectedLanes,
    input  logic [2:0]            expectedType,
    input  logic [4:0]            comparatorsCount,
    input  logic [MAXLANES-1:0]   osValid,
    input  logic [3*MAXLANES-1:0] osType,
    input  logic [MAXLANES-1:0]   osMatch,
    output logic [15:0]           countersComparators
);

    logic [2:0]          r_expType;
    logic                w_typeChange;
    logic [MAXLANES-1:0] w_active;
    logic [MAXLANES-1:0] w_reached;

    // Remember the last expected type. It resets to OS_NONE, so the first edge
    // after reset counts as a change whenever a real type is already applied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_expType <= OS_NONE;
        end else begin
            r_expType <= expectedType;
        end
    end

    assign w_typeChange = (expectedType != r_expType);

    for (genvar g = 0; g < MAXLANES; g++) begin : gLane
        assign w_active[g] = (5'(g) < numberOfDetectedLanes);

        os_lane_counter #(
            .CNTW (CNTW)
        ) uLane (
            .clk            (clk),
            .reset          (reset),
            .i_enable       (resetOsCheckers[g] && w_active[g]),
            .i_clear        (w_typeChange),
            .i_osValid      (osValid[g]),
            .i_osType       (osType[3*g +: 3]),
            .i_osMatch      (osMatch[g]),
            .i_expectedType (expectedType),
            .i_target       (comparatorsCount),
            .o_reached      (w_reached[g])
        );
    end

    // Lanes beyond MAXLANES read as 0.
    assign countersComparators = 16'(w_reached);

endmodule
